// File: rtl/cdc_xfer_sched.sv
// Round-robin scheduler that shares one clock-domain-crossing hold register among NREQ requesters.
// Everything runs on Aclk; Bclk_in is only ever sampled as data through the synchronizer chain.
module cdc_xfer_sched #(
    parameter int NREQ       = 4,
    parameter int DW         = 8,
    parameter int HOLD_EDGES = 2
) (
    input  logic                    Aclk,
    input  logic                    reset,
    input  logic                    Bclk_in,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      data_in,
    output logic [NREQ-1:0]         ack,
    output logic [DW-1:0]           hold_data,
    output logic                    hold_valid,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(HOLD_EDGES + 1);
    localparam logic [GW:0]   NREQ_W   = (GW+1)'(NREQ);
    localparam logic [CW-1:0] EDGE_MAX = CW'(HOLD_EDGES);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, ACK} xferState;

    xferState          stateReg, stateNext;
    logic [3:0]        syncReg;
    logic              edgePulse;
    logic [GW-1:0]     rrReg, rrNext;
    logic [GW-1:0]     grantReg, grantNext;
    logic [DW-1:0]     holdReg, holdNext;
    logic              validReg, validNext;
    logic [CW-1:0]     edgeCntReg, edgeCntNext;

    logic [DW-1:0]     slice [NREQ];
    logic [2*NREQ-1:0] reqTwice;
    logic [NREQ-1:0]   reqRot;
    logic [GW-1:0]     rotPos;
    logic [GW:0]       winSum;
    logic [GW-1:0]     winner;
    logic [GW:0]       grantInc;
    logic [GW-1:0]     rrWrap;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign slice[gi] = data_in[gi*DW +: DW];
        end
    endgenerate

    // Rotate the request vector so the search always starts at bit 0, then map back.
    assign reqTwice = {req, req};
    assign reqRot   = reqTwice[rrReg +: NREQ];

    always_comb begin
        rotPos = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (reqRot[k]) begin
                rotPos = GW'(k);
            end
        end
    end

    always_comb begin
        winSum = {1'b0, rrReg} + {1'b0, rotPos};
        if (winSum >= NREQ_W) begin
            winSum = winSum - NREQ_W;
        end
    end

    assign winner   = winSum[GW-1:0];
    assign grantInc = {1'b0, grantReg} + (GW+1)'(1);
    assign rrWrap   = (grantInc == NREQ_W) ? '0 : grantInc[GW-1:0];

    // s1..s4 live in syncReg[0..3]; s4 exists only to detect the rise of s3.
    always_ff @(posedge Aclk or negedge reset) begin
        if (!reset) begin
            syncReg <= '0;
        end else begin
            syncReg <= {syncReg[2:0], Bclk_in};
        end
    end

    assign edgePulse = syncReg[2] & ~syncReg[3];

    always_ff @(posedge Aclk or negedge reset) begin
        if (!reset) begin
            stateReg   <= IDLE;
            rrReg      <= '0;
            grantReg   <= '0;
            holdReg    <= '0;
            validReg   <= 1'b0;
            edgeCntReg <= '0;
        end else begin
            stateReg   <= stateNext;
            rrReg      <= rrNext;
            grantReg   <= grantNext;
            holdReg    <= holdNext;
            validReg   <= validNext;
            edgeCntReg <= edgeCntNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        rrNext      = rrReg;
        grantNext   = grantReg;
        holdNext    = holdReg;
        validNext   = validReg;
        edgeCntNext = edgeCntReg;
        ack         = '0;
        unique case (stateReg)
            IDLE: begin
                if (|req) begin
                    grantNext = winner;
                    stateNext = LOAD;
                end
            end
            LOAD: begin
                holdNext    = slice[grantReg];
                validNext   = 1'b1;
                edgeCntNext = '0;
                stateNext   = HOLD;
            end
            HOLD: begin
                // Count and exit test share the cycle of the final edge pulse.
                if (edgePulse) begin
                    if (edgeCntReg != EDGE_MAX) begin
                        edgeCntNext = edgeCntReg + CW'(1);
                    end
                    if (edgeCntNext == EDGE_MAX) begin
                        stateNext = ACK;
                    end
                end
            end
            ACK: begin
                ack[grantReg] = 1'b1;
                validNext     = 1'b0;
                rrNext        = rrWrap;
                stateNext     = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign hold_data  = holdReg;
    assign hold_valid = validReg;
    assign grant_id   = grantReg;
    assign busy       = (stateReg != IDLE);

endmodule

// File: tb/tb_cdc_xfer_sched.sv
// Randomized bench for cdc_xfer_sched against a transaction-timeline reference model.
module tb_cdc_xfer_sched;

    localparam int NREQ       = 4;
    localparam int DW         = 8;
    localparam int HOLD_EDGES = 2;
    localparam int GW         = $clog2(NREQ);
    localparam int MAXC       = 20000;

    logic                 Aclk    = 1'b0;
    logic                 reset   = 1'b1;
    logic                 Bclk_in = 1'b0;
    logic [NREQ-1:0]      req     = '0;
    logic [NREQ*DW-1:0]   data_in = '0;
    logic [NREQ-1:0]      ack;
    logic [DW-1:0]        hold_data;
    logic                 hold_valid;
    logic [GW-1:0]        grant_id;
    logic                 busy;

    cdc_xfer_sched #(.NREQ(NREQ), .DW(DW), .HOLD_EDGES(HOLD_EDGES)) dut (
        .Aclk       (Aclk),
        .reset      (reset),
        .Bclk_in    (Bclk_in),
        .req        (req),
        .data_in    (data_in),
        .ack        (ack),
        .hold_data  (hold_data),
        .hold_valid (hold_valid),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 Aclk = ~Aclk;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int lastRst = 0;
    bit bHist [MAXC];

    logic [NREQ-1:0]    reqPending = '0;
    logic [NREQ*DW-1:0] dataBus    = '0;
    bit rstDrive   = 1'b0;
    bit autoClear  = 1'b1;
    bit bclkRandom = 1'b0;
    bit bclkStall  = 1'b0;
    int bclkPeriod = 8;
    int bclkPhase  = 0;
    logic [NREQ-1:0] dutAcks [$];

    // Reference model: one transfer is a timeline (grant, load cycle, ack cycle).
    bit            mActive;
    bit            mValid;
    int            mLoad;
    int            mAck;
    int            mEdges;
    int            mRr;
    int            mGrant;
    logic [DW-1:0] mData;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit bAt(input int j);
        if (j <= lastRst || j < 0) return 1'b0;
        return bHist[j];
    endfunction

    function automatic int pickWinner(input logic [NREQ-1:0] r, input int p);
        for (int o = 0; o < NREQ; o++) begin
            if (r[(p + o) % NREQ]) return (p + o) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] ackAt(input int idx);
        if (idx < 0 || idx >= dutAcks.size()) return '0;
        return dutAcks[idx];
    endfunction

    task automatic modelReset();
        mActive = 1'b0;
        mValid  = 1'b0;
        mLoad   = -10;
        mAck    = -10;
        mEdges  = 0;
        mRr     = 0;
        mGrant  = 0;
        mData   = '0;
    endtask

    // Advance the model from the current cycle to the next one.
    task automatic advance(input bit pulse);
        if (!mActive) begin
            if (reqPending != '0) begin
                mGrant  = pickWinner(reqPending, mRr);
                mActive = 1'b1;
                mLoad   = cyc + 1;
                mAck    = -10;
                mEdges  = 0;
            end
        end else if (cyc == mLoad) begin
            mData  = dataBus[mGrant*DW +: DW];
            mValid = 1'b1;
        end else if (cyc == mAck) begin
            mValid  = 1'b0;
            mRr     = (mGrant + 1) % NREQ;
            mActive = 1'b0;
        end else if (pulse) begin
            mEdges++;
            if (mEdges == HOLD_EDGES) mAck = cyc + 1;
        end
    endtask

    task automatic step();
        bit pulse;
        bit bc;
        logic [NREQ-1:0] expAck;
        @(negedge Aclk);
        cyc++;
        pulse  = bAt(cyc - 2) && !bAt(cyc - 3);
        expAck = (mActive && cyc == mAck) ? NREQ'(1 << mGrant) : '0;
        checkEq("busy",       32'(busy),       32'(mActive));
        checkEq("ack",        32'(ack),        32'(expAck));
        checkEq("grant_id",   32'(grant_id),   32'(mGrant));
        checkEq("hold_data",  32'(hold_data),  32'(mData));
        checkEq("hold_valid", 32'(hold_valid), 32'(mValid));
        if (ack != '0) dutAcks.push_back(ack);
        if (autoClear) reqPending &= ~expAck;
        if (bclkRandom) begin
            bc = ($urandom_range(3) == 0) ? !Bclk_in : Bclk_in;
        end else if (bclkStall) begin
            bc = 1'b0;
        end else begin
            bclkPhase = (bclkPhase + 1) % bclkPeriod;
            bc = (bclkPhase < bclkPeriod / 2);
        end
        req     = reqPending;
        data_in = dataBus;
        Bclk_in = bc;
        reset   = rstDrive;
        bHist[cyc + 1] = bc;
        if (!rstDrive) begin
            modelReset();
            lastRst = cyc + 1;
        end else begin
            advance(pulse);
        end
    endtask

    task automatic runTransfers(input int nAcks, input string tag);
        int target;
        target = dutAcks.size() + nAcks;
        for (int i = 0; i < 3000 && dutAcks.size() < target; i++) step();
        checkEq({tag, "_acks"}, 32'(dutAcks.size()), 32'(target));
    endtask

    task automatic settle();
        for (int i = 0; i < 200 && mActive; i++) step();
        repeat (2) step();
    endtask

    initial begin
        int base;
        modelReset();
        #1 reset = 1'b0;

        // Reset held while inputs toggle, then quiet release.
        bclkRandom = 1'b1;
        repeat (12) begin
            reqPending = NREQ'($urandom);
            dataBus    = $urandom;
            step();
        end
        reqPending = '0;
        rstDrive   = 1'b1;
        bclkRandom = 1'b0;
        repeat (20) step();
        checkEq("idle_busy", 32'(busy), 32'(0));
        checkEq("idle_noack", 32'(dutAcks.size()), 32'(0));

        // Round-robin with all requesters held high.
        dataBus    = 32'h4433_2211;
        reqPending = 4'b1111;
        autoClear  = 1'b0;
        base       = dutAcks.size();
        runTransfers(5, "rr");
        reqPending = '0;
        autoClear  = 1'b1;
        settle();
        for (int j = 0; j < 5; j++) checkEq("rr_order", 32'(ackAt(base + j)), 32'(1 << (j % NREQ)));

        // Single transfer from requester 1.
        dataBus    = 32'h0000_A500;
        reqPending = 4'b0010;
        runTransfers(1, "single");
        settle();
        checkEq("single_ack", 32'(ackAt(dutAcks.size() - 1)), 32'h2);
        checkEq("single_grant", 32'(grant_id), 32'(1));
        checkEq("single_busy", 32'(busy), 32'(0));
        checkEq("single_keep", 32'(hold_data), 32'hA5);

        // Wrap: serve 2 so the pointer sits at 3, then 3 beats 0.
        dataBus    = $urandom;
        reqPending = 4'b0100;
        runTransfers(1, "wrap_pre");
        settle();
        checkEq("wrap_pre", 32'(ackAt(dutAcks.size() - 1)), 32'h4);
        reqPending = 4'b1001;
        base       = dutAcks.size();
        runTransfers(2, "wrap");
        settle();
        checkEq("wrap_first", 32'(ackAt(base)), 32'h8);
        checkEq("wrap_second", 32'(ackAt(base + 1)), 32'h1);

        // Abort with reset after the first counted edge.
        dataBus    = $urandom;
        reqPending = 4'b0001;
        base       = dutAcks.size();
        for (int i = 0; i < 500 && !(mActive && cyc > mLoad && mEdges == 1); i++) step();
        checkEq("abort_inhold", 32'(hold_valid), 32'(1));
        rstDrive = 1'b0;
        repeat (3) step();
        checkEq("abort_valid", 32'(hold_valid), 32'(0));
        checkEq("abort_data", 32'(hold_data), 32'(0));
        checkEq("abort_noack", 32'(dutAcks.size()), 32'(base));
        rstDrive = 1'b1;
        runTransfers(1, "abort_redo");
        settle();
        checkEq("abort_redo_ack", 32'(ackAt(dutAcks.size() - 1)), 32'h1);

        // Stalled slow clock, then resume.
        dataBus    = $urandom;
        reqPending = 4'b0010;
        base       = dutAcks.size();
        for (int i = 0; i < 50 && !(mActive && cyc > mLoad); i++) step();
        bclkStall = 1'b1;
        repeat (200) step();
        checkEq("stall_busy", 32'(busy), 32'(1));
        checkEq("stall_valid", 32'(hold_valid), 32'(1));
        checkEq("stall_noack", 32'(dutAcks.size()), 32'(base));
        bclkStall = 1'b0;
        bclkPhase = 0;
        runTransfers(1, "stall_resume");
        settle();
        checkEq("stall_ack", 32'(ackAt(dutAcks.size() - 1)), 32'h2);

        // Random traffic, random slow clock, occasional reset pulses.
        bclkRandom = 1'b1;
        repeat (3000) begin
            if ($urandom_range(5) == 0) reqPending[$urandom_range(NREQ - 1)] = 1'b1;
            if ($urandom_range(49) == 0) reqPending[$urandom_range(NREQ - 1)] = 1'b0;
            if ($urandom_range(3) == 0) dataBus = $urandom;
            if (!rstDrive) rstDrive = 1'b1;
            else if ($urandom_range(399) == 0) rstDrive = 1'b0;
            step();
        end
        rstDrive   = 1'b1;
        bclkRandom = 1'b0;
        reqPending = '0;
        settle();
        checkEq("final_busy", 32'(busy), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
